// File: rtl/mar_ram_pkg.sv
// Shared definitions for the MAR / program-RAM block: default widths and
// the control state encoding used by the programming handshake.
package mar_ram_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    P_IDLE  = 2'd1,
    P_WRITE = 2'd2,
    P_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/mar_ram_ram16x8.sv
// Program/data store: synchronous write, asynchronous (zero-latency) read.
// Contents are deliberately not reset so a loaded program survives clr.
module ram16x8 #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Write port: one word per enabled rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mar_ram.sv
// Memory address register plus 16x8 RAM on an OR-style bus. In RUN the MAR
// loads from the bus and the addressed word is gated onto bus_out; a small
// handshake FSM lets the RAM be filled one word at a time before run mode.
module mar_ram
  import mar_ram_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] bus_in,
  input  logic          Lm,
  input  logic          CE,
  output logic [DW-1:0] bus_out,
  output logic [AW-1:0] mar_q,
  input  logic          prog_en,
  input  logic          prog_valid,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic          prog_ready,
  output logic          prog_done,
  output logic          busy
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] mar_r;
  logic [AW-1:0] lat_addr_r;
  logic [DW-1:0] lat_data_r;
  logic          we_s;
  logic [DW-1:0] rdata_s;

  // State register; clr always returns to RUN.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic for run mode and the three-step programming handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (prog_en) begin
          state_nxt_s = P_IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      P_IDLE: begin
        if (prog_valid) begin
          state_nxt_s = P_WRITE;
        end else if (!prog_en) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = P_IDLE;
        end
      end
      P_WRITE: begin
        state_nxt_s = P_ACK;
      end
      P_ACK: begin
        if (prog_en) begin
          state_nxt_s = P_IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    busy       = 1'b1;
    case (state_r)
      RUN: begin
        busy = 1'b0;
      end
      P_IDLE: begin
        prog_ready = 1'b1;
      end
      P_WRITE: begin
        prog_ready = 1'b0;
      end
      P_ACK: begin
        prog_done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // MAR: loads from the bus only in RUN, otherwise holds.
  always_ff @(posedge clk) begin
    if (clr) begin
      mar_r <= {AW{1'b0}};
    end else if ((state_r == RUN) && Lm) begin
      mar_r <= bus_in;
    end else begin
      mar_r <= mar_r;
    end
  end

  // Capture the programming word on handshake so later changes on the
  // programming inputs cannot corrupt the pending write.
  always_ff @(posedge clk) begin
    if (clr) begin
      lat_addr_r <= {AW{1'b0}};
      lat_data_r <= {DW{1'b0}};
    end else if ((state_r == P_IDLE) && prog_valid) begin
      lat_addr_r <= prog_addr;
      lat_data_r <= prog_data;
    end else begin
      lat_addr_r <= lat_addr_r;
      lat_data_r <= lat_data_r;
    end
  end

  // A clr coinciding with the write cycle cancels the write.
  assign we_s = (state_r == P_WRITE) && !clr;

  ram16x8 #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (lat_addr_r),
    .wdata (lat_data_r),
    .raddr (mar_r),
    .rdata (rdata_s)
  );

  // Bus gating: only RUN with CE drives data, everything else presents zero.
  always_comb begin
    if ((state_r == RUN) && CE) begin
      bus_out = rdata_s;
    end else begin
      bus_out = {DW{1'b0}};
    end
  end

  assign mar_q = mar_r;

endmodule

// File: tb/tb_mar_ram.sv
// Self-checking bench for mar_ram: directed scenarios followed by random
// traffic, all compared against a transaction-level model kept here.
module tb_mar_ram;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] bus_in;
  logic       Lm;
  logic       CE;
  logic [7:0] bus_out;
  logic [3:0] mar_q;
  logic       prog_en;
  logic       prog_valid;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic       busy;

  always #5 clk = ~clk;

  mar_ram dut (
    .clk        (clk),
    .clr        (clr),
    .bus_in     (bus_in),
    .Lm         (Lm),
    .CE         (CE),
    .bus_out    (bus_out),
    .mar_q      (mar_q),
    .prog_en    (prog_en),
    .prog_valid (prog_valid),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the block should be doing, in spec terms.
  typedef enum {M_RUN, M_IDLE, M_WRITE, M_ACK} mode_t;
  mode_t      m_mode = M_RUN;
  logic [3:0] m_mar  = 4'd0;
  logic [7:0] m_mem [16];
  bit         m_known [16];
  logic [3:0] m_pa;
  logic [7:0] m_pd;
  int         cyc = 0;
  int         done_t[$];

  task automatic check_outputs();
    chk("mar_q", mar_q, m_mar);
    chk("busy", busy, (m_mode != M_RUN));
    chk("prog_ready", prog_ready, (m_mode == M_IDLE));
    chk("prog_done", prog_done, (m_mode == M_ACK));
    if (m_mode == M_RUN && CE) begin
      if (m_known[m_mar]) chk("bus_out", bus_out, m_mem[m_mar]);
    end else begin
      chk("bus_out_zero", bus_out, 8'h00);
    end
    if (prog_done) done_t.push_back(cyc);
  endtask

  task automatic model_edge();
    if (clr) begin
      m_mode = M_RUN;
      m_mar  = 4'd0;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (Lm) m_mar = bus_in;
          if (prog_en) m_mode = M_IDLE;
        end
        M_IDLE: begin
          if (prog_valid) begin
            m_pa = prog_addr;
            m_pd = prog_data;
            m_mode = M_WRITE;
          end else if (!prog_en) begin
            m_mode = M_RUN;
          end
        end
        M_WRITE: begin
          m_mem[m_pa]   = m_pd;
          m_known[m_pa] = 1'b1;
          m_mode = M_ACK;
        end
        default: m_mode = prog_en ? M_IDLE : M_RUN;
      endcase
    end
  endtask

  // One clock: check current outputs, take the edge, return at negedge.
  task automatic tick(input bit do_check = 1'b1);
    #1;
    if (do_check) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int gap;
    clr = 1'b1; bus_in = 4'd0; Lm = 1'b0; CE = 1'b0;
    prog_en = 1'b0; prog_valid = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
    @(negedge clk);
    tick(1'b0);
    clr = 1'b0;

    // Preload every word so later reads are fully predictable.
    prog_en = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) begin
      prog_valid = 1'b1; prog_addr = a[3:0]; prog_data = 8'($urandom_range(0, 255));
      tick();
      prog_valid = 1'b0;
      tick();
      tick();
    end
    prog_en = 1'b0;
    tick();

    // Two back-to-back words, prog_valid held through WRITE/ACK.
    done_t.delete();
    prog_en = 1'b1;
    tick();
    prog_valid = 1'b1; prog_addr = 4'd3; prog_data = 8'hA5;
    tick();
    prog_addr = 4'd15; prog_data = 8'h3C;
    tick();
    tick();
    tick();
    prog_valid = 1'b0;
    tick();
    prog_en = 1'b0;
    tick();
    tick();
    chk("done_count", done_t.size(), 2);
    gap = (done_t.size() == 2) ? done_t[1] - done_t[0] : -1;
    chk("done_gap", gap, 3);
    chk("busy_after_prog", busy, 1'b0);

    // Readback.
    bus_in = 4'd3; Lm = 1'b1;
    tick();
    Lm = 1'b0; CE = 1'b1;
    #1 chk("rd_addr3", bus_out, 8'hA5);
    tick();
    bus_in = 4'd15; Lm = 1'b1; CE = 1'b0;
    tick();
    Lm = 1'b0; CE = 1'b1;
    #1 chk("rd_addr15", bus_out, 8'h3C);
    tick();
    CE = 1'b0;
    #1 chk("rd_ce_off", bus_out, 8'h00);
    tick();

    // Lm and CE together: old word before the edge, new word after.
    bus_in = 4'd3; Lm = 1'b1;
    tick();
    bus_in = 4'd15; Lm = 1'b1; CE = 1'b1;
    #1 chk("lmce_before", bus_out, 8'hA5);
    tick();
    Lm = 1'b0;
    #1 chk("lmce_after", bus_out, 8'h3C);
    tick();

    // Gating while in programming mode.
    CE = 1'b0; prog_en = 1'b1;
    tick();
    bus_in = 4'd7; Lm = 1'b1; CE = 1'b1;
    tick();
    Lm = 1'b0;
    #1 chk("gate_mar", mar_q, 4'd15);
    chk("gate_bus", bus_out, 8'h00);
    prog_en = 1'b0; CE = 1'b0;
    tick();

    // clr during the write cycle cancels the write.
    prog_en = 1'b1;
    tick();
    prog_valid = 1'b1; prog_addr = 4'd3; prog_data = 8'hFF;
    tick();
    prog_valid = 1'b0; prog_en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    #1 chk("clr_write_busy", busy, 1'b0);
    bus_in = 4'd3; Lm = 1'b1;
    tick();
    Lm = 1'b0; CE = 1'b1;
    #1 chk("clr_write_kept", bus_out, 8'hA5);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clr        = ($urandom_range(0, 24) == 0);
      Lm         = $urandom_range(0, 1);
      CE         = $urandom_range(0, 1);
      bus_in     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) prog_en = ~prog_en;
      prog_valid = $urandom_range(0, 1);
      prog_addr  = 4'($urandom_range(0, 15));
      prog_data  = 8'($urandom_range(0, 255));
      tick();
    end

    // Reset after random activity.
    clr = 1'b1; CE = 1'b0; Lm = 1'b1; prog_en = 1'b1; prog_valid = 1'b1;
    tick();
    clr = 1'b0; Lm = 1'b0; prog_en = 1'b0; prog_valid = 1'b0;
    #1;
    chk("rst_mar", mar_q, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", prog_ready, 1'b0);
    chk("rst_done", prog_done, 1'b0);
    chk("rst_bus", bus_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
